blink_multi: RTL
================

# blink_multi

Multi-channel successor to the single-channel blink counter. Runs CHANNELS independent wrap counters of CBITS bits, each with a run-time programmable period and LED mode, producing one-cycle wrap flags and LED drive levels. Sits between the register/config interface and the board LED pins; the wrap flags also feed the formal property harness.

## Interface
- CHANNELS, default 4: number of independent blink channels (≥1).
- CBITS, default 12: counter and period width per channel.
- CHW, default $clog2(CHANNELS) clamped to ≥1: width of the channel select field; derived, not overridable.

- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  reset, synchronous and active-low: sampled on rising clk, asserted when 0.
- en  input  CHANNELS  per-channel count enable; 0 freezes that channel's counter, phase, led.
- cfg_we  input  1  config write strobe, single cycle.
- cfg_ch  input  CHW  target channel of the write.
- cfg_period  input  CBITS  terminal count P; the channel wraps every P+1 enabled cycles.
- cfg_mode  input  2  LED mode: 00 off, 01 on, 10 blink, 11 pulse.
- led  output  CHANNELS  registered LED drive.
- flg  output  CHANNELS  registered one-cycle wrap flag.

## Operation
- Per-channel state: cnt[CBITS], period[CBITS], mode[2], phase[1].
- Wrap event for channel i: en[i]=1 and cnt==period, with no config write to i in the same cycle.
- On each clk edge, in priority order:
  - Reset: cnt=0, phase=0, period=all ones, mode=10, led=0, flg=0 on all channels.
  - Config write (cfg_we=1, cfg_ch<CHANNELS): loads period and mode, sets cnt=0 and phase=0, flg=0, led=0. Overrides a coincident wrap. Writes with cfg_ch≥CHANNELS are ignored entirely.
  - Wrap: cnt=0, phase toggles, flg=1.
  - en[i]=1 without wrap: cnt+1, flg=0.
  - en[i]=0: cnt, phase, led hold; flg=0.
- LED decode, registered on the same edge as the state update and using the next-state values:
  - mode 00: led=0.
  - mode 01: led=1.
  - mode 10: led=new phase.
  - mode 11: led=1 exactly when flg is 1, otherwise 0.
- Counter arithmetic is unsigned CBITS. cnt never exceeds period, because writes clear cnt, so no overflow path exists.
- period=0: every enabled cycle is a wrap, so flg stays 1 continuously while en=1 and phase toggles each cycle.
- Channels are fully independent. Simultaneous wraps on several channels are all reported in the same cycle.

## Timing
- Latency: flg[i] rises on the edge where cnt transitions period→0. It is high for exactly one cycle unless the next enabled cycle is also a wrap (period=0).
- With en held at 1 and period P, flg pulses at cycles P+1, 2(P+1), … counted from reset release or from a config write.
- A config write takes effect on the next edge. The first wrap after a write occurs P+1 enabled cycles later.
- Reset applied mid-count clears everything on that edge. Outputs read 0 from the cycle after rst is sampled low.
- Dropping en mid-count holds state; counting resumes on the next enabled cycle with no lost or duplicated wrap.
- Required property, per channel, for period≥1: flg[i] is never high on two consecutive cycles. Also, in mode 10, led[i] changes only on cycles where flg[i] rises.

## Test plan
- Reset default: rst low 2 cycles, then en=1 on all channels for 8192 cycles. flg[0] pulses at cycles 4096 and 8192. led[0] reads 1 after the first wrap and 0 after the second.
- Programmed period: write ch1 P=3, mode 10, en[1]=1. flg[1] pulses every 4 cycles, and led[1] toggles 0→1→0 on each pulse.
- Mode decode: write ch2 P=2 with each of modes 00, 01 and 11 in turn. Required led[2] is constant 0, constant 1, and equal to flg[2] (1 every 3rd cycle), respectively.
- Write/wrap collision: hold ch0 at cnt==period and issue a write P=5 in the same cycle. flg[0] stays 0, and the next flg[0] pulse arrives 6 cycles later. Also write cfg_ch=CHANNELS (e.g. 4 with CHANNELS=5 is valid, so use CHANNELS=4 and cfg_ch=4 with CHW=2 unreachable; use CHANNELS=3 and cfg_ch=3): no state changes.
- Enable gating and reset: with P=3, toggle en[3] every other cycle, then flg[3] pulses every 8 cycles. Pull rst low at cnt=2, and all led/flg read 0 on the following cycle.
- period=0 edge case: write ch1 P=0 with en[1]=1. flg[1] is high on every cycle and led[1] (mode 10) alternates each cycle.

Source files
------------

// File: rtl/blink_multi.sv
// Multi-channel blink counter: independent wrap counters with programmable
// period and LED mode, registered one-cycle wrap flags and LED drive.
module blink_multi #(
  parameter int CHANNELS = 4,
  parameter int CBITS    = 12,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [CBITS-1:0]    cfg_period,
  input  logic [1:0]          cfg_mode,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] flg
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  logic [CBITS-1:0]    cnt_q    [CHANNELS];
  logic [CBITS-1:0]    cnt_d    [CHANNELS];
  logic [CBITS-1:0]    period_q [CHANNELS];
  logic [CBITS-1:0]    period_d [CHANNELS];
  mode_e               mode_q   [CHANNELS];
  mode_e               mode_d   [CHANNELS];
  logic [CHANNELS-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0] led_q,   led_d;
  logic [CHANNELS-1:0] flg_q,   flg_d;

  always_comb begin
    phase_d = phase_q;
    led_d   = led_q;
    flg_d   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i]    = cnt_q[i];
      period_d[i] = period_q[i];
      mode_d[i]   = mode_q[i];

      // Channels at or above CHANNELS never match, so out-of-range writes drop out.
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        period_d[i] = cfg_period;
        mode_d[i]   = mode_e'(cfg_mode);
        cnt_d[i]    = '0;
        phase_d[i]  = 1'b0;
        led_d[i]    = 1'b0;
      end else if (en[i]) begin
        if (cnt_q[i] == period_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
          flg_d[i]   = 1'b1;
        end else begin
          cnt_d[i]   = cnt_q[i] + CBITS'(1);
        end

        case (mode_q[i])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = phase_d[i];
          MODE_PULSE: led_d[i] = flg_d[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= '1;
        mode_q[i]   <= MODE_BLINK;
      end
      phase_q <= '0;
      led_q   <= '0;
      flg_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      flg_q    <= flg_d;
    end
  end

  assign led = led_q;
  assign flg = flg_q;

endmodule
